// File: rtl/load_register.sv
// Clock-enabled data register with byte-lane write strobes, synchronous clear
// and a one-cycle update pulse. Define LOAD_REGISTER_PARITY_EN to add an even-parity output.
module load_register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(32'h0000_0000)
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               load,
  input  logic [WIDTH/8-1:0] byte_en,
  input  logic               clr,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
`ifdef LOAD_REGISTER_PARITY_EN
  output logic               parity,
`endif
  output logic               updated
);

  localparam int NUM_LANES = WIDTH / 8;

  logic [WIDTH-1:0] q_q, q_d;
  logic             updated_q, updated_d;

  // Priority: clear beats load beats hold.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    q_d       = q_q;
    updated_d = 1'b0;
    if (clr) begin
      q_d       = RESET_VALUE;
      updated_d = 1'b1;
    end else if (load) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byte_en[i]) begin
          q_d[8*i +: 8] = D[8*i +: 8];
        end
      end
      updated_d = |byte_en;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      q_q       <= RESET_VALUE;
      updated_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      q_q       <= q_d;
      updated_q <= updated_d;
    end
  end

  assign Q       = q_q;
  assign updated = updated_q;

`ifdef LOAD_REGISTER_PARITY_EN
  // Parity is registered from the next-state value so it moves with Q.
  logic parity_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      parity_q <= ^RESET_VALUE;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_load_register.sv
// Self-checking bench for load_register: directed steps plus randomized
// traffic compared against a mask-based reference model.
module tb_load_register;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        load;
  logic [3:0]  byte_en;
  logic        clr;
  logic [31:0] D;
  logic [31:0] Q;
  logic        updated;
`ifdef LOAD_REGISTER_PARITY_EN
  logic        parity;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state.
  logic [31:0] m_q;
  logic        m_upd;

  load_register #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (load),
    .byte_en (byte_en),
    .clr     (clr),
    .D       (D),
    .Q       (Q),
`ifdef LOAD_REGISTER_PARITY_EN
    .parity  (parity),
`endif
    .updated (updated)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-strobe mask: each set strobe bit opens one 8-bit lane.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    if (be[0]) m = m + 32'h0000_00FF;
    if (be[1]) m = m + 32'h0000_FF00;
    if (be[2]) m = m + 32'h00FF_0000;
    if (be[3]) m = m + 32'hFF00_0000;
    return m;
  endfunction

  task automatic model_edge(input logic l, input logic c, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] m;
    if (c) begin
      m_q   = RV;
      m_upd = 1'b1;
    end else if (l) begin
      m     = lane_mask(be);
      m_q   = (m_q & ~m) | (d & m);
      m_upd = (be != 4'h0);
    end else begin
      m_upd = 1'b0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".Q"}, Q, m_q);
    check({tag, ".updated"}, {31'h0, updated}, {31'h0, m_upd});
`ifdef LOAD_REGISTER_PARITY_EN
    check({tag, ".parity"}, {31'h0, parity}, {31'h0, ^m_q});
    check({tag, ".even"}, {31'h0, ^{Q, parity}}, 32'h0);
`endif
  endtask

  // Called at a negedge: apply inputs, take one rising edge, compare #1 later.
  task automatic step(input string tag, input logic l, input logic c,
                      input logic [3:0] be, input logic [31:0] d);
    load = l; clr = c; byte_en = be; D = d;
    @(posedge HCLK);
    model_edge(l, c, be, d);
    #1;
    compare_model(tag);
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    load    = 1'b1;
    clr     = 1'b0;
    byte_en = 4'hF;
    D       = 32'hDEAD_BEEF;
    m_q     = RV;
    m_upd   = 1'b0;

    // Reset held across edges with a pending write.
    #2;
    check("rst_q", Q, 32'h0);
    check("rst_upd", {31'h0, updated}, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hold_q", Q, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    step("idle_after_rst", 1'b0, 1'b0, 4'hF, 32'hDEAD_BEEF);
    check("idle_after_rst_q", Q, 32'h0);

    step("full_write", 1'b1, 1'b0, 4'hF, 32'h1234_5678);
    check("full_write_q", Q, 32'h1234_5678);
    check("full_write_upd", {31'h0, updated}, 32'h1);
    step("full_idle", 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF);
    check("full_idle_q", Q, 32'h1234_5678);
    check("full_idle_upd", {31'h0, updated}, 32'h0);

    step("lanes", 1'b1, 1'b0, 4'b0101, 32'hAABB_CCDD);
    check("lanes_q", Q, 32'h12BB_56DD);
    step("no_lanes", 1'b1, 1'b0, 4'b0000, 32'h0000_0000);
    check("no_lanes_q", Q, 32'h12BB_56DD);
    check("no_lanes_upd", {31'h0, updated}, 32'h0);

    step("set_ones", 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF);
    step("clr_prio", 1'b1, 1'b1, 4'hF, 32'h5555_5555);
    check("clr_prio_q", Q, RV);
    check("clr_prio_upd", {31'h0, updated}, 32'h1);

    for (int i = 1; i <= 3; i++) begin
      step("b2b", 1'b1, 1'b0, 4'hF, 32'(i));
      check("b2b_q", Q, 32'(i));
      check("b2b_upd", {31'h0, updated}, 32'h1);
    end

`ifdef LOAD_REGISTER_PARITY_EN
    step("par7", 1'b1, 1'b0, 4'hF, 32'h0000_0007);
    check("par7_bit", {31'h0, parity}, 32'h1);
    step("par3", 1'b1, 1'b0, 4'hF, 32'h0000_0003);
    check("par3_bit", {31'h0, parity}, 32'h0);
`endif

    // Randomized traffic; clear kept rare so loads dominate.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           4'($urandom), $urandom);
    end

    // Reset asserted mid-cycle while a write is pending.
    step("pre_mid", 1'b1, 1'b0, 4'hF, 32'hCAFE_F00D);
    load = 1'b1; byte_en = 4'hF; D = 32'hDEAD_BEEF; clr = 1'b0;
    #2;
    HRESETn = 1'b0;
    m_q   = RV;
    m_upd = 1'b0;
    #1;
    check("mid_rst_q", Q, 32'h0);
    check("mid_rst_upd", {31'h0, updated}, 32'h0);
    @(posedge HCLK);
    #1;
    compare_model("mid_rst_edge");
    @(negedge HCLK);
    HRESETn = 1'b1;
    step("post_mid", 1'b0, 1'b0, 4'h0, 32'h0);
    check("post_mid_q", Q, 32'h0);
    step("post_mid_wr", 1'b1, 1'b0, 4'b1000, 32'hA5A5_A5A5);
    check("post_mid_wr_q", Q, 32'hA500_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_register.md
Name: load_register

Overview:
- Parameterised, clock-enabled data register with byte-lane write strobes, synchronous clear and a one-cycle update pulse.
- Used as the storage element behind AHB-Lite slave register slots.
- The slave drives `load` one cycle after the address phase and presents `HWDATA` on `D`.
- `Q` feeds the slave's register output ports directly.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8, minimum 8.
- RESET_VALUE, 32'h0000_0000, value of Q after reset and after a synchronous clear; truncated to WIDTH.

Ports:
- HCLK  input  1  system clock; all state changes on its rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- load  input  1  write enable; when high at a rising edge, the enabled byte lanes of D are captured.
- byte_en  input  WIDTH/8  per-byte write strobe; bit i enables Q[8i+7:8i]. Tie all-ones for full-word writes.
- clr  input  1  synchronous clear to RESET_VALUE.
- D  input  WIDTH  write data.
- Q  output  WIDTH  stored value, driven directly from flops.
- updated  output  1  registered pulse; high for the cycle after any edge where Q was written or cleared.

Behaviour:
- Interface: reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset:
  - HRESETn low forces Q = RESET_VALUE and updated = 0 immediately, independent of HCLK.
  - Deassertion is synchronous to HCLK; the first write is possible at the first rising edge with HRESETn high.
- Priority at each rising edge, highest first: clr, then load, then hold.
- clr = 1: Q <= RESET_VALUE (all lanes, byte_en ignored); updated <= 1.
- clr = 0, load = 1:
  - For each lane i with byte_en[i] = 1: Q[8i+7:8i] <= D[8i+7:8i].
  - Lanes with byte_en[i] = 0 hold their value.
  - updated <= 1 if any byte_en bit is set; else updated <= 0.
- clr = 0, load = 0: Q holds; updated <= 0.
- Latency:
  - Q reflects new data one cycle after the capturing edge; there is no combinational path from D to Q.
  - updated is asserted in that same cycle.
- Back-to-back loads on consecutive cycles each capture; the last one wins. updated stays high continuously.
- Reset mid-write: an asserted HRESETn overrides any load or clr in the same cycle; Q = RESET_VALUE.
- D, byte_en and clr are don't-care while load = 0 and clr = 0.
- Undriven or X inputs are not specified; the bench drives all inputs at all times.

Optional Feature:
- Macro: LOAD_REGISTER_PARITY_EN.
- When defined:
  - Adds output `parity` (1 bit), a registered even parity of Q, so that `^{Q, parity} == 0` always.
  - parity updates in the same cycle as Q.
  - Reset value is ^RESET_VALUE.
- When undefined:
  - Port `parity` does not exist; no extra logic is generated.

Test Plan:
- Reset:
  - Assert HRESETn = 0 mid-cycle with load = 1 and D = 32'hDEAD_BEEF → Q = 32'h0000_0000 immediately; updated = 0.
  - Release HRESETn → Q holds 0 until the first load.
- Full write:
  - load = 1, byte_en = 4'hF, D = 32'h1234_5678 for one edge → next cycle Q = 32'h1234_5678, updated = 1.
  - Following cycle with load = 0 → updated = 0, Q unchanged.
- Byte lanes:
  - From Q = 32'h1234_5678, load = 1, byte_en = 4'b0101, D = 32'hAABB_CCDD → Q = 32'h12BB_56DD.
  - Then byte_en = 4'b0000 with load = 1 → Q unchanged, updated = 0.
- Clear priority: Q = 32'hFFFF_FFFF, clr = 1 and load = 1 with D = 32'h5555_5555 on the same edge → Q = RESET_VALUE, updated = 1.
- Back-to-back: load = 1 for 3 consecutive edges with D = 1, 2, 3 → Q = 1, 2, 3 on successive cycles; updated high for 3 cycles.
- Parity (with LOAD_REGISTER_PARITY_EN):
  - Write 32'h0000_0007 → parity = 1.
  - Write 32'h0000_0003 → parity = 0.
  - Check ^{Q, parity} == 0 every cycle.
